// File: rtl/mult_pipe.sv
// mult_pipe: four-stage pipelined 32x32 multiplier feeding the writeback Mult slot.
// Returns the high or low half of the signed or unsigned 64-bit product, holds its
// result when writeback is taken by Mem/AluMisc, and exports a pending-dest mask.
//
// Handshake: an op is accepted on a rising edge when iss_mul_oper && mul_iss_ready.
// mul_iss_ready is combinational and may fall in the same cycle as a writeback
// conflict. On the writeback side, the S4 op retires when mul_wb_oper is high and
// either it does not write a register or neither mem_wb_oper nor am_wb_oper is high.
module mult_pipe (
   input  logic        clock,
   input  logic        reset,
   input  logic        iss_mul_oper,
   input  logic [31:0] iss_mul_a,
   input  logic [31:0] iss_mul_b,
   input  logic        iss_mul_signed,
   input  logic        iss_mul_high,
   input  logic [4:0]  iss_mul_regdest,
   input  logic        iss_mul_writereg,
   output logic        mul_iss_ready,
   input  logic        mul_flush,
   input  logic        mem_wb_oper,
   input  logic        am_wb_oper,
   output logic        mul_wb_oper,
   output logic [4:0]  mul_wb_regdest,
   output logic        mul_wb_writereg,
   output logic [31:0] mul_wb_wbvalue,
   output logic [31:0] mul_pend_mask
);

   // stage valid bits
   logic v1, v2, v3, v4;

   // stage 1: extended operands plus metadata
   logic [32:0] a1, b1;
   logic        h1, wr1;
   logic [4:0]  rd1;

   // stage 2: partial products plus metadata
   logic [49:0] pl2, ph2;
   logic        h2, wr2;
   logic [4:0]  rd2;

   // stage 3: full 64-bit product plus metadata
   logic [63:0] p3;
   logic        h3, wr3;
   logic [4:0]  rd3;

   // advance signals: adv_k means stage k's contents move forward this edge
   logic retire4, adv4, adv3, adv2, adv1;

   // partial-product operands, sign-extended to the 50-bit product width
   logic [49:0] a_ext, blo_ext, bhi_ext, pl_d, ph_d;
   logic [63:0] sum_d;

   assign v4       = mul_wb_oper;
   assign retire4  = v4 && (~mul_wb_writereg || (~mem_wb_oper && ~am_wb_oper));
   assign adv4     = ~v4 || retire4;
   assign adv3     = ~v4 || adv4;
   assign adv2     = ~v3 || adv3;
   assign adv1     = ~v2 || adv2;
   assign mul_iss_ready = ~v1 || adv1;

   // A33 * B[15:0] and A33 * B[32:16]; only the low 50 bits matter, so the
   // multiply is done on sign-extended operands without signed types.
   assign a_ext   = {{17{a1[32]}}, a1};
   assign blo_ext = {34'd0, b1[15:0]};
   assign bhi_ext = {{33{b1[32]}}, b1[32:16]};
   assign pl_d    = a_ext * blo_ext;
   assign ph_d    = a_ext * bhi_ext;
   assign sum_d   = ({{14{ph2[49]}}, ph2} << 16) + {{14{pl2[49]}}, pl2};

   // valid bits: flush and reset clear every stage; otherwise move on advance
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         mul_wb_oper <= 1'b0;
      end else if (mul_flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         mul_wb_oper <= 1'b0;
      end else begin
         if (mul_iss_ready) v1 <= iss_mul_oper;
         if (adv1)          v2 <= v1;
         if (adv2)          v3 <= v2;
         if (adv3)          mul_wb_oper <= v3;
      end
   end

   // data and metadata: load on advance, hold otherwise (not cleared by flush)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a1  <= '0;
         b1  <= '0;
         h1  <= 1'b0;
         wr1 <= 1'b0;
         rd1 <= '0;
         pl2 <= '0;
         ph2 <= '0;
         h2  <= 1'b0;
         wr2 <= 1'b0;
         rd2 <= '0;
         p3  <= '0;
         h3  <= 1'b0;
         wr3 <= 1'b0;
         rd3 <= '0;
         mul_wb_wbvalue  <= '0;
         mul_wb_regdest  <= '0;
         mul_wb_writereg <= 1'b0;
      end else begin
         if (mul_iss_ready) begin
            a1  <= {iss_mul_signed & iss_mul_a[31], iss_mul_a};
            b1  <= {iss_mul_signed & iss_mul_b[31], iss_mul_b};
            h1  <= iss_mul_high;
            wr1 <= iss_mul_writereg;
            rd1 <= iss_mul_regdest;
         end
         if (adv1) begin
            pl2 <= pl_d;
            ph2 <= ph_d;
            h2  <= h1;
            wr2 <= wr1;
            rd2 <= rd1;
         end
         if (adv2) begin
            p3  <= sum_d;
            h3  <= h2;
            wr3 <= wr2;
            rd3 <= rd2;
         end
         if (adv3) begin
            mul_wb_wbvalue  <= h3 ? p3[63:32] : p3[31:0];
            mul_wb_regdest  <= rd3;
            mul_wb_writereg <= wr3;
         end
      end
   end

   // pending-destination mask over every valid, register-writing stage
   always_comb begin
      mul_pend_mask = '0;
      if (v1 && wr1) mul_pend_mask[rd1] = 1'b1;
      if (v2 && wr2) mul_pend_mask[rd2] = 1'b1;
      if (v3 && wr3) mul_pend_mask[rd3] = 1'b1;
      if (v4 && mul_wb_writereg) mul_pend_mask[mul_wb_regdest] = 1'b1;
      mul_pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed, table-driven bench for mult_pipe with an in-order
// result scoreboard and hand-written multi-cycle sequences.
module tb_mult_pipe;

   logic        clock;
   logic        reset;
   logic        iss_mul_oper;
   logic [31:0] iss_mul_a, iss_mul_b;
   logic        iss_mul_signed, iss_mul_high;
   logic [4:0]  iss_mul_regdest;
   logic        iss_mul_writereg;
   logic        mul_iss_ready;
   logic        mul_flush;
   logic        mem_wb_oper, am_wb_oper;
   logic        mul_wb_oper;
   logic [4:0]  mul_wb_regdest;
   logic        mul_wb_writereg;
   logic [31:0] mul_wb_wbvalue;
   logic [31:0] mul_pend_mask;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic        high;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   // expected results in order: {writereg, regdest, value}
   logic [37:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   mult_pipe dut (
      .clock            (clock),
      .reset            (reset),
      .iss_mul_oper     (iss_mul_oper),
      .iss_mul_a        (iss_mul_a),
      .iss_mul_b        (iss_mul_b),
      .iss_mul_signed   (iss_mul_signed),
      .iss_mul_high     (iss_mul_high),
      .iss_mul_regdest  (iss_mul_regdest),
      .iss_mul_writereg (iss_mul_writereg),
      .mul_iss_ready    (mul_iss_ready),
      .mul_flush        (mul_flush),
      .mem_wb_oper      (mem_wb_oper),
      .am_wb_oper       (am_wb_oper),
      .mul_wb_oper      (mul_wb_oper),
      .mul_wb_regdest   (mul_wb_regdest),
      .mul_wb_writereg  (mul_wb_writereg),
      .mul_wb_wbvalue   (mul_wb_wbvalue),
      .mul_pend_mask    (mul_pend_mask)
   );

   // clock and watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required earlier completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      iss_mul_oper     = 1'b0;
      iss_mul_a        = '0;
      iss_mul_b        = '0;
      iss_mul_signed   = 1'b0;
      iss_mul_high     = 1'b0;
      iss_mul_regdest  = '0;
      iss_mul_writereg = 1'b0;
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic high, input logic [4:0] rd, input logic wr,
                           input logic push, input logic [31:0] exp);
      iss_mul_oper     = 1'b1;
      iss_mul_a        = a;
      iss_mul_b        = b;
      iss_mul_signed   = sgn;
      iss_mul_high     = high;
      iss_mul_regdest  = rd;
      iss_mul_writereg = wr;
      if (push) exp_q.push_back({wr, rd, exp});
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // scoreboard: compare every retiring result with the head of the queue
   always @(negedge clock) begin
      logic [37:0] e;
      if (!reset && mul_wb_oper &&
          (!mul_wb_writereg || (!mem_wb_oper && !am_wb_oper))) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got value 0x%08h rd %0d, required no result at %0t",
                     mul_wb_wbvalue, mul_wb_regdest, $time);
         end else begin
            e = exp_q.pop_front();
            check("wb_value", mul_wb_wbvalue, e[31:0]);
            check("wb_regdest", {27'd0, mul_wb_regdest}, {27'd0, e[36:32]});
            check("wb_writereg", {31'd0, mul_wb_writereg}, {31'd0, e[37]});
         end
      end
   end

   initial begin
      vecs[0]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b0, 32'hFFFFFFF1};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE};
      vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001};
      vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000};
      vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001};
      vecs[5]  = '{32'd2,        32'd3,        1'b0, 1'b0, 32'd6};
      vecs[6]  = '{32'd4,        32'd5,        1'b0, 1'b0, 32'd20};
      vecs[7]  = '{32'd6,        32'd7,        1'b0, 1'b0, 32'd42};
      vecs[8]  = '{32'd8,        32'd9,        1'b0, 1'b0, 32'd72};
      vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000};
      vecs[10] = '{32'h80000000, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFF};
      vecs[11] = '{32'h12345678, 32'h00010000, 1'b0, 1'b0, 32'h56780000};
      vecs[12] = '{32'h12345678, 32'h00010000, 1'b0, 1'b1, 32'h00001234};
      vecs[13] = '{32'hFFFFFFFF, 32'd7,        1'b0, 1'b1, 32'h00000006};
      vecs[14] = '{32'hFFFFFFFF, 32'd7,        1'b1, 1'b1, 32'hFFFFFFFF};
      vecs[15] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h3FFFFFFF};

      // reset state
      reset = 1'b1;
      mul_flush = 1'b0;
      mem_wb_oper = 1'b0;
      am_wb_oper = 1'b0;
      idle();
      repeat (2) step();
      check("rst_oper", {31'd0, mul_wb_oper}, 32'd0);
      check("rst_regdest", {27'd0, mul_wb_regdest}, 32'd0);
      check("rst_writereg", {31'd0, mul_wb_writereg}, 32'd0);
      check("rst_value", mul_wb_wbvalue, 32'd0);
      check("rst_mask", mul_pend_mask, 32'd0);
      check("rst_ready", {31'd0, mul_iss_ready}, 32'd1);
      reset = 1'b0;

      // single signed-low op: latency and pending mask
      drive_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'hFFFFFFF1);
      for (int e = 0; e < 5; e++) begin
         step();
         if (e == 0) idle();
         check("lat_oper", {31'd0, mul_wb_oper}, (e == 3) ? 32'd1 : 32'd0);
         check("lat_mask", mul_pend_mask, (e < 4) ? 32'h00000080 : 32'd0);
      end

      // table vectors issued back-to-back
      for (int i = 0; i < NV; i++) begin
         drive_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].high, 5'(i + 1), 1'b1,
                  1'b1, vecs[i].exp);
         check("b2b_ready", {31'd0, mul_iss_ready}, 32'd1);
         step();
         if (i >= 3) check("b2b_oper", {31'd0, mul_wb_oper}, 32'd1);
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         step();
         check("b2b_tail_oper", {31'd0, mul_wb_oper}, 32'd1);
      end
      step();
      check("b2b_done_oper", {31'd0, mul_wb_oper}, 32'd0);
      drain(10);

      // writeback conflict: full pipe, Mem holds the slot for 5 cycles
      for (int i = 0; i < 4; i++) begin
         drive_op(32'(10 + i), 32'd3, 1'b0, 1'b0, 5'(i + 1), 1'b1, 1'b1, 32'(30 + 3 * i));
         step();
      end
      idle();
      mem_wb_oper = 1'b1;
      #1;
      check("stall_ready", {31'd0, mul_iss_ready}, 32'd0);
      check("stall_mask", mul_pend_mask, 32'h0000001E);
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_oper", {31'd0, mul_wb_oper}, 32'd1);
         check("stall_value", mul_wb_wbvalue, 32'd30);
         check("stall_ready", {31'd0, mul_iss_ready}, 32'd0);
      end
      mem_wb_oper = 1'b0;
      #1;
      check("release_ready", {31'd0, mul_iss_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("release_oper", {31'd0, mul_wb_oper}, 32'd1);
      end
      step();
      check("release_done_oper", {31'd0, mul_wb_oper}, 32'd0);
      drain(10);

      // writereg=0 op retires even while AluMisc owns the slot
      am_wb_oper = 1'b1;
      drive_op(32'd3, 32'd3, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 32'd9);
      for (int e = 0; e < 5; e++) begin
         step();
         if (e == 0) idle();
         check("nowr_oper", {31'd0, mul_wb_oper}, (e == 3) ? 32'd1 : 32'd0);
         check("nowr_mask", mul_pend_mask, 32'd0);
      end
      am_wb_oper = 1'b0;
      drain(10);

      // regdest 0 with writereg 1 passes through but stays out of the mask
      drive_op(32'd5, 32'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'd25);
      step();
      idle();
      check("rd0_mask", mul_pend_mask, 32'd0);
      drain(10);

      // flush with three ops in flight and a fourth presented
      for (int i = 0; i < 3; i++) begin
         drive_op(32'(i + 1), 32'd1, 1'b0, 1'b0, 5'(20 + i), 1'b1, 1'b0, 32'd0);
         step();
      end
      drive_op(32'd4, 32'd1, 1'b0, 1'b0, 5'd23, 1'b1, 1'b0, 32'd0);
      mul_flush = 1'b1;
      check("preflush_mask", mul_pend_mask, 32'h00700000);
      step();
      mul_flush = 1'b0;
      idle();
      check("flush_mask", mul_pend_mask, 32'd0);
      check("flush_oper", {31'd0, mul_wb_oper}, 32'd0);
      check("flush_ready", {31'd0, mul_iss_ready}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("postflush_oper", {31'd0, mul_wb_oper}, 32'd0);
      end

      // asynchronous reset with two ops in flight
      drive_op(32'd7, 32'd7, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 32'd0);
      step();
      drive_op(32'd8, 32'd8, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 32'd0);
      step();
      idle();
      #2;
      reset = 1'b1;
      #1;
      check("arst_oper", {31'd0, mul_wb_oper}, 32'd0);
      check("arst_value", mul_wb_wbvalue, 32'd0);
      check("arst_regdest", {27'd0, mul_wb_regdest}, 32'd0);
      check("arst_mask", mul_pend_mask, 32'd0);
      check("arst_ready", {31'd0, mul_iss_ready}, 32'd1);
      #1;
      reset = 1'b0;
      drive_op(32'h00010000, 32'h00010000, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 32'd1);
      for (int e = 0; e < 5; e++) begin
         step();
         if (e == 0) idle();
         check("postrst_oper", {31'd0, mul_wb_oper}, (e == 3) ? 32'd1 : 32'd0);
      end
      drain(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
